// File: rtl/relu_argmax.sv
// relu_argmax: output stage of the MNIST accelerator.
//
// Waits for every output-layer PE to raise its done flag, captures all PE
// words through an FP32 ReLU, then scans the rectified lanes one per cycle
// to find the winning class. The result holds until the next `head`.
//
// Ports:
//   clock        rising-edge clock shared with the PE array
//   rst_n        asynchronous active-low reset
//   head         inference header pulse; re-arms the block (top priority)
//   pe_out_bus   N_OUT packed FP32 PE outputs, lane k at [32k+31:32k]
//   done_vec     per-PE done flags, bit k belongs to PE k
//   relu_bus     registered ReLU of the captured lanes, same packing
//   class_idx    index of the largest rectified lane (lowest index on ties)
//   max_val      FP32 value at class_idx
//   result_valid high while class_idx/max_val hold a completed result
//   busy         high while the scan is in progress
module relu_argmax #(
  parameter int N_OUT = 10,
  parameter int IDX_W = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  head,
  input  logic [32*N_OUT-1:0]   pe_out_bus,
  input  logic [N_OUT-1:0]      done_vec,
  output logic [32*N_OUT-1:0]   relu_bus,
  output logic [IDX_W-1:0]      class_idx,
  output logic [31:0]           max_val,
  output logic                  result_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {WAIT, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      relu_q [N_OUT];
  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_lane;
  logic             last_lane;
  logic             capture;

  // Negative values and every NaN rectify to +0; +Inf and positive
  // denormals pass through unchanged.
  function automatic logic [31:0] fp32_relu(input logic [31:0] w);
    logic is_nan;
    is_nan = (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    if (w[31] || is_nan) return 32'd0;
    return w;
  endfunction

  assign capture   = (state == WAIT) && (&done_vec);
  assign cur_lane  = relu_q[idx];
  assign last_lane = (idx == IDX_W'(N_OUT - 1));

  // busy/result_valid are decodes of the state register only.
  assign busy         = (state == SCAN);
  assign result_valid = (state == DONE);

  for (genvar k = 0; k < N_OUT; k++) begin : g_pack
    assign relu_bus[32*k +: 32] = relu_q[k];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (head) begin
      state_nxt = WAIT;
    end else begin
      case (state)
        WAIT:    if (&done_vec) state_nxt = SCAN;
        SCAN:    if (last_lane) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = WAIT;
      endcase
    end
  end

  // Capture on entry to SCAN, then one lane per cycle. The compare uses
  // bits [30:0] as unsigned integers: rectified lanes are non-negative and
  // never NaN, so integer order equals FP32 order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) relu_q[k] <= 32'd0;
      class_idx <= '0;
      max_val   <= 32'd0;
      idx       <= '0;
    end else if (head) begin
      class_idx <= '0;
      max_val   <= 32'd0;
      idx       <= '0;
    end else if (capture) begin
      for (int k = 0; k < N_OUT; k++) relu_q[k] <= fp32_relu(pe_out_bus[32*k +: 32]);
      class_idx <= '0;
      max_val   <= 32'd0;
      idx       <= '0;
    end else if (state == SCAN) begin
      if (cur_lane[30:0] > max_val[30:0]) begin
        max_val   <= cur_lane;
        class_idx <= idx;
      end
      if (!last_lane) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_relu_argmax.sv
// Self-checking bench for relu_argmax: a behavioural model (lanes scanned so
// far, prefix argmax) compared against the DUT every cycle, plus directed
// literal expectations and randomized inferences.
module tb_relu_argmax;
  localparam int N_OUT = 10;
  localparam int IDX_W = 4;
  localparam int BW    = 32 * N_OUT;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              head  = 1'b0;
  logic [BW-1:0]     pe_out_bus = '0;
  logic [N_OUT-1:0]  done_vec = '0;
  logic [BW-1:0]     relu_bus;
  logic [IDX_W-1:0]  class_idx;
  logic [31:0]       max_val;
  logic              result_valid;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  relu_argmax #(.N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
    .clock(clock), .rst_n(rst_n), .head(head), .pe_out_bus(pe_out_bus),
    .done_vec(done_vec), .relu_bus(relu_bus), .class_idx(class_idx),
    .max_val(max_val), .result_valid(result_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ref_relu(input logic [31:0] w);
    if (w[31]) return 32'd0;
    if (w[30:23] == 8'hFF && w[22:0] != 0) return 32'd0;
    return w;
  endfunction

  logic [31:0] m_lane [N_OUT];
  bit          m_armed = 1'b1;
  int          m_cnt   = 0;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_armed <= 1'b1;
      m_cnt   <= 0;
      for (int k = 0; k < N_OUT; k++) m_lane[k] <= 32'd0;
    end else if (head) begin
      m_armed <= 1'b1;
      m_cnt   <= 0;
    end else if (m_armed) begin
      if (&done_vec) begin
        m_armed <= 1'b0;
        m_cnt   <= 0;
        for (int k = 0; k < N_OUT; k++) m_lane[k] <= ref_relu(pe_out_bus[32*k +: 32]);
      end
    end else if (m_cnt < N_OUT) begin
      m_cnt <= m_cnt + 1;
    end
  end

  // First index holding the largest value among lanes 0..len-1.
  task automatic prefix_argmax(input int len, output int bi, output logic [31:0] bv);
    bi = 0;
    bv = 32'd0;
    for (int k = 0; k < len; k++)
      if (m_lane[k] > bv) begin bi = k; bv = m_lane[k]; end
  endtask

  always @(negedge clock) begin
    int          ei;
    logic [31:0] ev;
    logic [BW-1:0] eb;
    for (int k = 0; k < N_OUT; k++) eb[32*k +: 32] = m_lane[k];
    if (m_armed) begin ei = 0; ev = 0; end
    else prefix_argmax(m_cnt, ei, ev);
    check("relu_bus",     relu_bus, eb);
    check("class_idx",    BW'(class_idx), BW'(ei));
    check("max_val",      BW'(max_val), BW'(ev));
    check("busy",         BW'(busy), BW'(!m_armed && m_cnt < N_OUT));
    check("result_valid", BW'(result_valid), BW'(!m_armed && m_cnt == N_OUT));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_head();
    head = 1'b1;
    tick();
    head = 1'b0;
    done_vec = '0;
  endtask

  // Capture `bus`, then wait (bounded) for result_valid and check latency.
  task automatic run(input logic [BW-1:0] bus);
    int cyc;
    pe_out_bus = bus;
    done_vec   = '1;
    tick();
    check("busy_after_capture", BW'(busy), BW'(1));
    cyc = 0;
    while (!result_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    check("valid_latency", BW'(cyc), BW'(N_OUT));
  endtask

  function automatic logic [BW-1:0] fill(input logic [31:0] v);
    logic [BW-1:0] b;
    for (int k = 0; k < N_OUT; k++) b[32*k +: 32] = v;
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    int sel;
    logic [31:0] w;
    sel = $urandom_range(0, 9);
    w   = $urandom;
    case (sel)
      0, 1:    return {1'b1, w[30:0]};
      2:       return {w[31], 8'hFF, (w[22:0] == 0) ? 23'd1 : w[22:0]};
      3:       return 32'd0;
      4:       return 32'h7F800000;
      5:       return 32'h3FC00000;
      default: return {1'b0, w[30:0]};
    endcase
  endfunction

  initial begin
    logic [BW-1:0] bus;
    int n;
    #12 rst_n = 1'b1;
    tick();
    check("reset_busy",  BW'(busy), BW'(0));
    check("reset_valid", BW'(result_valid), BW'(0));
    check("reset_relu",  relu_bus, '0);

    // Basic argmax
    bus = fill(32'h3E800000);
    bus[31:0] = 32'h3F000000;
    bus[63:32] = 32'h3F800000;
    bus[95:64] = 32'h40500000;
    run(bus);
    check("basic_class", BW'(class_idx), BW'(2));
    check("basic_max",   BW'(max_val), BW'(32'h40500000));
    check("basic_busy_low", BW'(busy), BW'(0));
    pulse_head();

    // ReLU of negatives and NaN
    bus = fill(32'hBF800000);
    bus[31:0]    = 32'hC0A00000;
    bus[127:96]  = 32'h7FC00000;
    bus[255:224] = 32'h40000000;
    run(bus);
    check("nan_relu_bus", relu_bus, BW'(32'h40000000) << (32*7));
    check("nan_class",    BW'(class_idx), BW'(7));
    pulse_head();

    // Ties keep the lower index
    bus = '0;
    bus[159:128] = 32'h3FC00000;
    bus[223:192] = 32'h3FC00000;
    run(bus);
    check("tie_class", BW'(class_idx), BW'(4));
    check("tie_max",   BW'(max_val), BW'(32'h3FC00000));
    pulse_head();

    // All negative
    run(fill(32'hC1200000));
    check("neg_class", BW'(class_idx), BW'(0));
    check("neg_max",   BW'(max_val), BW'(0));
    pulse_head();

    // Partial done, then no recapture while DONE
    bus = fill(32'h3F800000);
    bus[287:256] = 32'h41000000;
    pe_out_bus = bus;
    done_vec = 10'h3EF;
    for (int i = 0; i < 20; i++) tick();
    check("partial_busy", BW'(busy), BW'(0));
    run(bus);
    check("partial_class", BW'(class_idx), BW'(8));
    pe_out_bus = fill(32'h42000000);
    for (int i = 0; i < 5; i++) tick();
    check("norecap_class", BW'(class_idx), BW'(8));
    check("norecap_max",   BW'(max_val), BW'(32'h41000000));
    pulse_head();

    // head abort mid-scan, then +Inf wins
    pe_out_bus = fill(32'h3F800000);
    done_vec = '1;
    for (int i = 0; i < 5; i++) tick();
    pulse_head();
    check("abort_busy",  BW'(busy), BW'(0));
    check("abort_valid", BW'(result_valid), BW'(0));
    check("abort_class", BW'(class_idx), BW'(0));
    bus = fill(32'h7F7FFFFF);
    bus[319:288] = 32'h7F800000;
    run(bus);
    check("inf_class", BW'(class_idx), BW'(9));
    check("inf_max",   BW'(max_val), BW'(32'h7F800000));
    pulse_head();

    // Async reset mid-scan
    run(fill(32'h3F800000));
    pulse_head();
    pe_out_bus = fill(32'h40000000);
    done_vec = '1;
    for (int i = 0; i < 4; i++) tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_relu",  relu_bus, '0);
    check("arst_busy",  BW'(busy), BW'(0));
    check("arst_valid", BW'(result_valid), BW'(0));
    check("arst_max",   BW'(max_val), BW'(0));
    done_vec = '0;
    @(negedge clock);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("arst_wait_busy", BW'(busy), BW'(0));

    // Randomized inferences with partial done and occasional aborts
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N_OUT; k++) bus[32*k +: 32] = rand_word();
      pe_out_bus = bus;
      done_vec = N_OUT'($urandom) & ~(N_OUT'(1) << $urandom_range(0, N_OUT-1));
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) tick();
      done_vec = '1;
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(0, N_OUT);
        for (int i = 0; i < n; i++) tick();
        pulse_head();
      end else begin
        for (int i = 0; i < N_OUT + 3; i++) tick();
        pulse_head();
      end
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/relu_argmax.md
# relu_argmax

Output stage of the MNIST accelerator, directly downstream of the processing-element array. It waits until every PE in the output layer reports `done_flag`, then captures all `pe_out` words and applies ReLU. It scans the rectified FP32 values one per cycle, finds the winning class, and holds the result until the next `head` starts a new inference.

## Interface
Parameters:
- `N_OUT`, 10: number of PEs / classes feeding this block.
- `IDX_W`, 4: width of class index; must satisfy 2^IDX_W >= N_OUT.

Ports:
- `clock`  in  1  rising-edge clock shared with the PE array.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `head`  in  1  same header pulse the PEs receive; starts a new inference (re-arms this block).
- `pe_out_bus`  in  32*N_OUT  concatenated PE outputs; PE k occupies bits [32k+31:32k].
- `done_vec`  in  N_OUT  concatenated PE `done_flag`s; bit k belongs to PE k.
- `relu_bus`  out  32*N_OUT  registered ReLU of the captured PE outputs, same packing.
- `class_idx`  out  IDX_W  index of the maximum rectified value.
- `max_val`  out  32  FP32 value at `class_idx`.
- `result_valid`  out  1  level; high while `class_idx`/`max_val` hold a completed result.
- `busy`  out  1  high while the scan is in progress.

## Operation
- States: WAIT, SCAN, DONE. Reset state is WAIT.
- `head` has top priority in every state:
  - next state WAIT;
  - `result_valid`, `busy`, `class_idx`, `max_val` and the scan index are cleared;
  - `relu_bus` keeps its value.
- WAIT, when `&done_vec` = 1 and `head` = 0:
  - each lane k is rectified: relu_k = 0x00000000 if sign=1, or if exp=0xFF with mantissa≠0 (any NaN); otherwise relu_k = the input word (+Inf and positive denormals pass through);
  - `relu_bus` loads all rectified lanes;
  - `max_val` ← 0, `class_idx` ← 0, idx ← 0;
  - next state SCAN, `busy` = 1.
- SCAN, once per cycle:
  - compare relu[idx] against `max_val` as 31-bit unsigned integers (bits [30:0]); this is valid because all operands are non-negative and non-NaN;
  - on strict greater-than, `max_val` ← relu[idx] and `class_idx` ← idx;
  - ties keep the lower index; all-zero inputs give class 0 with `max_val` = 0;
  - on idx = N_OUT-1: next state DONE, `busy` ← 0, `result_valid` ← 1. Otherwise idx ← idx+1.
- DONE:
  - outputs hold;
  - `done_vec` staying high does NOT recapture;
  - leaves only on `head` or reset.
- `done_vec` partially high in WAIT: no action. A deasserting `done_vec` during SCAN is ignored.

## Timing
- Reset (async assert) values: state WAIT, `relu_bus` = 0, `class_idx` = 0, `max_val` = 0, `result_valid` = 0, `busy` = 0, idx = 0. Reset mid-SCAN aborts immediately.
- Capture edge E0: the first edge sampling `&done_vec` = 1 in WAIT. `relu_bus` and `busy` = 1 are visible after E0.
- Scan edges E1..E_N_OUT examine lanes 0..N_OUT-1.
- `result_valid` rises after edge E_N_OUT, i.e. N_OUT cycles after capture (10 with defaults). `busy` falls on the same edge.
- `head` on the same edge as the capture condition: `head` wins, no capture.
- After `head` the PEs clear `done_flag` on that same edge, so WAIT sees `&done_vec` = 0 on the next cycle. No spurious capture.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic argmax.** After reset, lanes = {0.5, 1.0, 3.25 (0x40500000) at k=2, others 0.25}; set all `done_vec` → capture. Required: `busy` for 10 cycles; `result_valid` rises 10 cycles after capture; `class_idx` = 2; `max_val` = 0x40500000.
- **ReLU, negatives and NaN.** Lane 0 = -5.0 (0xC0A00000), lane 3 = 0x7FC00000 (NaN), lane 7 = 2.0, others -1.0. Required: `relu_bus` lanes 0, 3 and non-7 lanes = 0; lane 7 = 0x40000000; `class_idx` = 7.
- **Ties and all-nonpositive.** Lanes 4 and 6 = 1.5, others 0 → `class_idx` = 4. All lanes negative → `class_idx` = 0, `max_val` = 0.
- **Partial done / no recapture.** Only 9 bits of `done_vec` high for 20 cycles → stays WAIT, `busy` = 0. Raise the 10th bit → capture. In DONE, change `pe_out_bus` with `done_vec` still high → outputs unchanged.
- **`head` abort.** Pulse `head` at scan cycle 4 → next cycle `busy` = 0, `result_valid` = 0, `class_idx` = 0. A new capture with lane 9 = +Inf (0x7F800000) gives `class_idx` = 9.
- **Async reset mid-scan.** Drop `rst_n` mid-cycle during SCAN → all outputs 0 without waiting for a clock edge; after release the block is in WAIT.
